// File: rtl/pe_out_router.sv
// Output-side routing stage of a PE: registered N/E/W link outputs chosen from the ALU
// result or neighbour inputs, plus a configurable-length delay line feeding the DL link.
module pe_out_router #(
  parameter int DATA_W   = 16,
  parameter int DL_DEPTH = 4
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              EN,
  input  logic              CONF_WE,
  input  logic [7:0]        CONF_WDATA,
  input  logic [DATA_W-1:0] IN_ALU,
  input  logic [DATA_W-1:0] IN_SOUTH,
  input  logic [DATA_W-1:0] IN_EAST,
  input  logic [DATA_W-1:0] IN_WEST,
  output logic [DATA_W-1:0] OUT_NORTH,
  output logic [DATA_W-1:0] OUT_EAST,
  output logic [DATA_W-1:0] OUT_WEST,
  output logic [DATA_W-1:0] OUT_DL,
  output logic              OUT_DL_VALID,
  output logic [7:0]        CONF_Q
);

  logic [1:0]        sel_n;
  logic [1:0]        sel_e;
  logic [1:0]        sel_w;
  logic [1:0]        dl_len;
  logic [1:0]        new_len;
  logic              len_change;
  logic [2:0]        fc;
  logic [2:0]        fc_target;
  logic [DATA_W-1:0] stage [DL_DEPTH];

  assign sel_n      = CONF_Q[1:0];
  assign sel_e      = CONF_Q[3:2];
  assign sel_w      = CONF_Q[5:4];
  assign dl_len     = CONF_Q[7:6];
  assign new_len    = CONF_WDATA[7:6];
  assign len_change = CONF_WE && (new_len != dl_len);
  assign fc_target  = {1'b0, dl_len} + 3'd1;

  function automatic logic [DATA_W-1:0] route(
    input logic [1:0]        sel,
    input logic [DATA_W-1:0] alu,
    input logic [DATA_W-1:0] south,
    input logic [DATA_W-1:0] east,
    input logic [DATA_W-1:0] west
  );
    case (sel)
      2'd0:    route = alu;
      2'd1:    route = south;
      2'd2:    route = east;
      default: route = west;
    endcase
  endfunction

  // Data path reads the configuration as it stood before this edge, so a
  // same-edge config write only affects the following enabled edge.
  always_ff @(posedge CLK) begin
    if (RST) begin
      CONF_Q    <= '0;
      OUT_NORTH <= '0;
      OUT_EAST  <= '0;
      OUT_WEST  <= '0;
      fc        <= '0;
      for (int i = 0; i < DL_DEPTH; i++) stage[i] <= '0;
    end else begin
      if (CONF_WE) CONF_Q <= CONF_WDATA;
      if (EN) begin
        OUT_NORTH <= route(sel_n, IN_ALU, IN_SOUTH, IN_EAST, IN_WEST);
        OUT_EAST  <= route(sel_e, IN_ALU, IN_SOUTH, IN_EAST, IN_WEST);
        OUT_WEST  <= route(sel_w, IN_ALU, IN_SOUTH, IN_EAST, IN_WEST);
        stage[0]  <= IN_ALU;
        for (int i = 1; i < DL_DEPTH; i++) stage[i] <= stage[i-1];
      end
      // A length change restarts the fill count; stage contents stay in place.
      if (len_change) fc <= '0;
      else if (EN && (fc < fc_target)) fc <= fc + 3'd1;
    end
  end

  assign OUT_DL       = stage[dl_len];
  assign OUT_DL_VALID = (fc == fc_target);

endmodule
